mmap_voice_regs: RTL

- Parametrised memory-mapped control block for a multi-voice synth. Generalises the single-voice note registers to NUM_VOICES voices.
- Adds per-voice lifecycle tracking, registered one-cycle command pulses, an active-voice mask and corrected cycle/instruction counters.
- Sits between the CPU MMIO decode (16-bit offset, 3-bit select) and NUM_VOICES signal-chain instances. UART, FIFO and PWM stay outside.

---
 rtl/mmap_voice_regs.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mmap_voice_regs.sv
// Memory-mapped control block for NUM_VOICES synth voices: note registers, per-voice lifecycle FSMs,
// registered command pulses and cycle/instruction counters. Define MMAP_VOICE_IRQ_EN for the finished-voice irq.
module mmap_voice_regs #(
  parameter int          NUM_VOICES   = 4,
  parameter logic [15:0] VOICE_BASE   = 16'h1000,
  parameter logic [15:0] VOICE_STRIDE = 16'h0020,
  parameter int          FCW_WIDTH    = 24,
  parameter int          SHIFT_WIDTH  = 5
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [15:0]                     addr_i,
  input  logic [2:0]                      mmap_sel_i,
  input  logic [31:0]                     data_i,
  output logic [31:0]                     dout_o,
  output logic [NUM_VOICES*FCW_WIDTH-1:0] fcw_o,
  output logic [NUM_VOICES-1:0]           note_start_o,
  output logic [NUM_VOICES-1:0]           note_release_o,
  output logic [NUM_VOICES-1:0]           note_reset_o,
  input  logic [NUM_VOICES-1:0]           note_finished_i,
  output logic [SHIFT_WIDTH-1:0]          sine_shift_o,
  output logic [SHIFT_WIDTH-1:0]          square_shift_o,
  output logic [SHIFT_WIDTH-1:0]          triangle_shift_o,
  output logic [SHIFT_WIDTH-1:0]          sawtooth_shift_o,
  output logic [SHIFT_WIDTH-1:0]          global_gain_o,
  output logic                            irq_o
);

  localparam int STRIDE_LG = $clog2(VOICE_STRIDE);
  localparam logic [2:0] SEL_LOAD = 3'd1, SEL_STORE = 3'd2, SEL_BUBBLE = 3'd6;

  // state | meaning: IDLE 0 silent | ACTIVE 1 playing | RELEASED 2 waiting note_finished | FINISHED 3 done
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RELEASED = 2'd2, FINISHED = 2'd3} voice_state_e;

  logic ld, st, in_voice, cnt_clr;
  logic [15:0] voff, woff;
  logic [2:0]  vsel;
  logic [NUM_VOICES-1:0] hit, cmd_rst, cmd_start, cmd_rel, ld_fin, act;

  voice_state_e state_q [NUM_VOICES];
  voice_state_e state_d [NUM_VOICES];
  logic [NUM_VOICES-1:0][FCW_WIDTH-1:0] fcw_q, fcw_d;
  logic [NUM_VOICES-1:0] start_q, start_d, release_q, release_d, reset_q, reset_d;
  logic [SHIFT_WIDTH-1:0] sine_q, sine_d, square_q, square_d, tri_q, tri_d, saw_q, saw_d, gain_q, gain_d;
  logic [31:0] cyc_q, cyc_d, instr_q, instr_d, dout_q, dout_d, rdata;
  logic unused_bits;

  assign unused_bits = ^data_i;
  assign ld = en_i && (mmap_sel_i == SEL_LOAD);
  assign st = en_i && (mmap_sel_i == SEL_STORE);
  assign cnt_clr = st && (addr_i == 16'h0018);

  always_comb begin
    voff     = addr_i - VOICE_BASE;
    woff     = voff & (VOICE_STRIDE - 16'd1);
    vsel     = voff[STRIDE_LG +: 3];
    in_voice = (addr_i >= VOICE_BASE) && ((voff >> STRIDE_LG) < 16'(NUM_VOICES));
    for (int v = 0; v < NUM_VOICES; v++) begin
      hit[v]       = in_voice && (vsel == 3'(v));
      cmd_rst[v]   = st && ((addr_i == 16'h0100) || (hit[v] && woff == 16'h0010));
      cmd_start[v] = st && hit[v] && (woff == 16'h0004);
      cmd_rel[v]   = st && hit[v] && (woff == 16'h0008);
      ld_fin[v]    = ld && hit[v] && (woff == 16'h000C);
      act[v]       = (state_q[v] == ACTIVE) || (state_q[v] == RELEASED);
    end
  end

  always_comb begin
    fcw_d     = fcw_q;
    start_d   = '0;
    release_d = '0;
    reset_d   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      state_d[v] = state_q[v];
      if (st && hit[v] && woff == 16'h0000) fcw_d[v] = data_i[FCW_WIDTH-1:0];
      if (cmd_rst[v]) begin
        state_d[v] = IDLE;
        reset_d[v] = 1'b1;
      end else if (cmd_start[v]) begin
        state_d[v] = ACTIVE;
        start_d[v] = 1'b1;
      end else if (cmd_rel[v] && state_q[v] == ACTIVE) begin
        state_d[v]   = RELEASED;
        release_d[v] = 1'b1;
      end else if (en_i && state_q[v] == RELEASED && note_finished_i[v]) begin
        state_d[v] = FINISHED;
      end
    end
  end

  always_comb begin
    sine_d   = (st && addr_i == 16'h0200) ? data_i[SHIFT_WIDTH-1:0] : sine_q;
    square_d = (st && addr_i == 16'h0204) ? data_i[SHIFT_WIDTH-1:0] : square_q;
    tri_d    = (st && addr_i == 16'h0208) ? data_i[SHIFT_WIDTH-1:0] : tri_q;
    saw_d    = (st && addr_i == 16'h020C) ? data_i[SHIFT_WIDTH-1:0] : saw_q;
    gain_d   = (st && addr_i == 16'h0104) ? data_i[SHIFT_WIDTH-1:0] : gain_q;
    cyc_d    = cnt_clr ? 32'd0 : cyc_q + 32'd1;
    instr_d  = instr_q;
    if (cnt_clr) instr_d = 32'd0;
    else if (en_i && mmap_sel_i != SEL_BUBBLE) instr_d = instr_q + 32'd1;
  end

`ifdef MMAP_VOICE_IRQ_EN
  logic [NUM_VOICES-1:0] irq_mask_q, irq_mask_d, pend_q, pend_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_mask_d = (st && addr_i == 16'h010C) ? data_i[NUM_VOICES-1:0] : irq_mask_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      pend_d[v] = pend_q[v];
      // Entry wins over a same-cycle FINISHED load: that load still returns the pre-entry 0.
      if (cmd_rst[v]) pend_d[v] = 1'b0;
      else if (state_d[v] == FINISHED && state_q[v] != FINISHED) pend_d[v] = 1'b1;
      else if (ld_fin[v]) pend_d[v] = 1'b0;
    end
    irq_d = |(pend_d & irq_mask_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_mask_q <= '0;
      pend_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (addr_i)
      16'h0010: rdata = cyc_q;
      16'h0014: rdata = instr_q;
      16'h0104: rdata = 32'(gain_q);
      16'h0108: rdata = 32'(act);
`ifdef MMAP_VOICE_IRQ_EN
      16'h010C: rdata = 32'(irq_mask_q);
`endif
      16'h0200: rdata = 32'(sine_q);
      16'h0204: rdata = 32'(square_q);
      16'h0208: rdata = 32'(tri_q);
      16'h020C: rdata = 32'(saw_q);
      default:  rdata = '0;
    endcase
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (hit[v]) begin
        case (woff)
          16'h0000: rdata = 32'(fcw_q[v]);
          16'h000C: rdata = {31'd0, state_q[v] == FINISHED};
          16'h0014: rdata = 32'(state_q[v]);
          default:  rdata = '0;
        endcase
      end
    end
    dout_d = ld ? rdata : dout_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < NUM_VOICES; v++) state_q[v] <= IDLE;
      fcw_q     <= '0;
      start_q   <= '0;
      release_q <= '0;
      reset_q   <= '0;
      sine_q    <= '0;
      square_q  <= '0;
      tri_q     <= '0;
      saw_q     <= '0;
      gain_q    <= '0;
      cyc_q     <= '0;
      instr_q   <= '0;
      dout_q    <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) state_q[v] <= state_d[v];
      fcw_q     <= fcw_d;
      start_q   <= start_d;
      release_q <= release_d;
      reset_q   <= reset_d;
      sine_q    <= sine_d;
      square_q  <= square_d;
      tri_q     <= tri_d;
      saw_q     <= saw_d;
      gain_q    <= gain_d;
      cyc_q     <= cyc_d;
      instr_q   <= instr_d;
      dout_q    <= dout_d;
    end
  end

  assign dout_o           = dout_q;
  assign fcw_o            = fcw_q;
  assign note_start_o     = start_q;
  assign note_release_o   = release_q;
  assign note_reset_o     = reset_q;
  assign sine_shift_o     = sine_q;
  assign square_shift_o   = square_q;
  assign triangle_shift_o = tri_q;
  assign sawtooth_shift_o = saw_q;
  assign global_gain_o    = gain_q;

endmodule
